// File: rtl/mem_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// mem_arbiter: shares one 12-bit word RAM between the CPU bus and the DMA/panel
// port. Optional MEM_ARB_STATS_EN adds grant and timeout statistics outputs.
// Revision: 1.0
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DMA_PRIORITY = 1,
  parameter int TIMEOUT      = 15,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_load,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [11:0] cpu_wdata,
  output logic [11:0] cpu_rdata,
  output logic        cpu_ready,
  input  logic        dma_load,
  input  logic        dma_we,
  input  logic [11:0] dma_addr,
  input  logic [11:0] dma_wdata,
  output logic [11:0] dma_rdata,
  output logic        dma_ready,
  output logic        dma_err,
  output logic        cpu_err,
  output logic        ram_load,
  output logic        ram_we,
  output logic [11:0] ram_addr,
  output logic [11:0] ram_wdata,
  input  logic [11:0] ram_rdata,
  input  logic        ram_ready,
  output logic [1:0]  owner
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [15:0] cpu_grants,
  output logic [15:0] dma_grants,
  output logic [7:0]  timeouts
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GNT_CPU = 2'd1,
    GNT_DMA = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_dma_q, last_dma_d;
  logic [11:0]       cpu_rdata_q, cpu_rdata_d;
  logic [11:0]       dma_rdata_q, dma_rdata_d;
  logic              tmo_expire;

  // Expiry is judged on the cycle whose registered count is TIMEOUT-1, so the
  // abort pulse lands on the TIMEOUT-th grant cycle.
  assign tmo_expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_dma_d  = last_dma_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    ram_load    = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;
    cpu_ready   = 1'b0;
    dma_ready   = 1'b0;
    cpu_err     = 1'b0;
    dma_err     = 1'b0;
    owner       = 2'b00;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cpu_load && dma_load) begin
          state_d = ((DMA_PRIORITY != 0) || !last_dma_q) ? GNT_DMA : GNT_CPU;
        end else if (cpu_load) begin
          state_d = GNT_CPU;
        end else if (dma_load) begin
          state_d = GNT_DMA;
        end
      end
      GNT_CPU: begin
        owner     = 2'b01;
        ram_load  = cpu_load;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        cnt_d     = cnt_q + CNT_W'(1);
        // Completion outranks a same-cycle drop or expiry.
        if (ram_ready) begin
          cpu_ready   = 1'b1;
          cpu_rdata_d = ram_rdata;
          last_dma_d  = 1'b0;
          state_d     = RELEASE;
        end else if (!cpu_load) begin
          state_d = RELEASE;
        end else if (tmo_expire) begin
          cpu_err = 1'b1;
          state_d = RELEASE;
        end
      end
      GNT_DMA: begin
        owner     = 2'b10;
        ram_load  = dma_load;
        ram_we    = dma_we;
        ram_addr  = dma_addr;
        ram_wdata = dma_wdata;
        cnt_d     = cnt_q + CNT_W'(1);
        if (ram_ready) begin
          dma_ready   = 1'b1;
          dma_rdata_d = ram_rdata;
          last_dma_d  = 1'b1;
          state_d     = RELEASE;
        end else if (!dma_load) begin
          state_d = RELEASE;
        end else if (tmo_expire) begin
          dma_err = 1'b1;
          state_d = RELEASE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign cpu_rdata = cpu_ready ? ram_rdata : cpu_rdata_q;
  assign dma_rdata = dma_ready ? ram_rdata : dma_rdata_q;

  // last_dma resets high so the first round-robin tie goes to the CPU.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_dma_q  <= 1'b1;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_dma_q  <= last_dma_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [15:0] cpu_grants_q, cpu_grants_d;
  logic [15:0] dma_grants_q, dma_grants_d;
  logic [7:0]  timeouts_q, timeouts_d;

  always_comb begin
    cpu_grants_d = cpu_grants_q;
    dma_grants_d = dma_grants_q;
    timeouts_d   = timeouts_q;
    if (state_q == IDLE && state_d == GNT_CPU) cpu_grants_d = cpu_grants_q + 16'd1;
    if (state_q == IDLE && state_d == GNT_DMA) dma_grants_d = dma_grants_q + 16'd1;
    if ((cpu_err || dma_err) && timeouts_q != 8'hFF) timeouts_d = timeouts_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_grants_q <= '0;
      dma_grants_q <= '0;
      timeouts_q   <= '0;
    end else begin
      cpu_grants_q <= cpu_grants_d;
      dma_grants_q <= dma_grants_d;
      timeouts_q   <= timeouts_d;
    end
  end

  assign cpu_grants = cpu_grants_q;
  assign dma_grants = dma_grants_q;
  assign timeouts   = timeouts_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: randomized bench; a transaction-level model predicts winner, grant
// timing, completion data and abort pulses for a DMA-priority and a round-robin instance.
module tb_mem_arbiter;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_load, cpu_we, dma_load, dma_we, ram_ready;
  logic [11:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, ram_rdata;

  logic [11:0] cpu_rdata_w [2];
  logic [11:0] dma_rdata_w [2];
  logic [11:0] ram_addr_w  [2];
  logic [11:0] ram_wdata_w [2];
  logic        cpu_ready_w [2];
  logic        dma_ready_w [2];
  logic        cpu_err_w   [2];
  logic        dma_err_w   [2];
  logic        ram_load_w  [2];
  logic        ram_we_w    [2];
  logic [1:0]  owner_w     [2];
`ifdef MEM_ARB_STATS_EN
  logic [15:0] cpu_grants_w [2];
  logic [15:0] dma_grants_w [2];
  logic [7:0]  timeouts_w   [2];
`endif

  always #5 clk = ~clk;

  mem_arbiter #(.DMA_PRIORITY(1), .TIMEOUT(TMO), .CNT_W(4)) u_dut_prio (
    .clk(clk), .rst(rst),
    .cpu_load(cpu_load), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_w[0]), .cpu_ready(cpu_ready_w[0]),
    .dma_load(dma_load), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata_w[0]), .dma_ready(dma_ready_w[0]),
    .dma_err(dma_err_w[0]), .cpu_err(cpu_err_w[0]),
    .ram_load(ram_load_w[0]), .ram_we(ram_we_w[0]), .ram_addr(ram_addr_w[0]),
    .ram_wdata(ram_wdata_w[0]), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .owner(owner_w[0])
`ifdef MEM_ARB_STATS_EN
    , .cpu_grants(cpu_grants_w[0]), .dma_grants(dma_grants_w[0]), .timeouts(timeouts_w[0])
`endif
  );

  mem_arbiter #(.DMA_PRIORITY(0), .TIMEOUT(TMO), .CNT_W(4)) u_dut_rr (
    .clk(clk), .rst(rst),
    .cpu_load(cpu_load), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata_w[1]), .cpu_ready(cpu_ready_w[1]),
    .dma_load(dma_load), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata_w[1]), .dma_ready(dma_ready_w[1]),
    .dma_err(dma_err_w[1]), .cpu_err(cpu_err_w[1]),
    .ram_load(ram_load_w[1]), .ram_we(ram_we_w[1]), .ram_addr(ram_addr_w[1]),
    .ram_wdata(ram_wdata_w[1]), .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .owner(owner_w[1])
`ifdef MEM_ARB_STATS_EN
    , .cpu_grants(cpu_grants_w[1]), .dma_grants(dma_grants_w[1]), .timeouts(timeouts_w[1])
`endif
  );

  int          md;          // 0: DMA-priority instance under check, 1: round-robin
  int          n_checks, n_errors;
  bit          m_last_dma;
  logic [11:0] m_cpu_rd, m_dma_rd;
  int          m_cpu_gr, m_dma_gr, m_to;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (mode %0d, t=%0t)", tag, got, exp, md, $time);
    end
  endtask

  function automatic logic [3:0] pulses();
    return {cpu_ready_w[md], dma_ready_w[md], cpu_err_w[md], dma_err_w[md]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last_dma = 1'b1;
    m_cpu_rd = '0; m_dma_rd = '0;
    m_cpu_gr = 0; m_dma_gr = 0; m_to = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    cpu_load = 1'b0; dma_load = 1'b0; ram_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    model_reset();
  endtask

  task automatic raise(input bit is_dma);
    if (is_dma) begin
      dma_we = 1'($urandom); dma_addr = 12'($urandom); dma_wdata = 12'($urandom); dma_load = 1'b1;
    end else begin
      cpu_we = 1'($urandom); cpu_addr = 12'($urandom); cpu_wdata = 12'($urandom); cpu_load = 1'b1;
    end
  endtask

  // Runs one arbitrated transaction starting in an idle cycle.
  // lat>0: RAM completes on grant cycle lat; lat==0: RAM silent; lat<0: requester drops.
  task automatic serve(input int lat, input logic [11:0] rd, input bit re_cpu,
                       input bit re_dma, input bit stray, output bit w);
    logic [11:0] ea, ed;
    logic        ewe;
    logic [3:0]  ep;
    bit          done;
    #1;
    check("idle_load", 16'(ram_load_w[md]), 16'd0);
    check("idle_owner", 16'(owner_w[md]), 16'd0);
    if (cpu_load && dma_load) w = (md == 0) ? 1'b1 : !m_last_dma;
    else w = dma_load;
    ea  = w ? dma_addr : cpu_addr;
    ed  = w ? dma_wdata : cpu_wdata;
    ewe = w ? dma_we : cpu_we;
    if (w) m_dma_gr++; else m_cpu_gr++;
    done = 1'b0;
    for (int k = 1; k <= TMO && !done; k++) begin
      tick();
      ram_ready = (lat == k);
      ram_rdata = rd;
      if (lat < 0 && k == 2) begin
        if (w) dma_load = 1'b0; else cpu_load = 1'b0;
      end
      #1;
      check("gnt_owner", 16'(owner_w[md]), w ? 16'd2 : 16'd1);
      if (lat < 0 && k == 2) begin
        check("drop_load", 16'(ram_load_w[md]), 16'd0);
        check("drop_pulse", 16'(pulses()), 16'd0);
        done = 1'b1;
      end else begin
        check("gnt_load", 16'(ram_load_w[md]), 16'd1);
        check("gnt_addr", 16'(ram_addr_w[md]), 16'(ea));
        check("gnt_wdata", 16'(ram_wdata_w[md]), 16'(ed));
        check("gnt_we", 16'(ram_we_w[md]), 16'(ewe));
        ep = 4'b0000;
        if (lat == k) begin
          ep = w ? 4'b0100 : 4'b1000;
          check("done_rdata", 16'(w ? dma_rdata_w[md] : cpu_rdata_w[md]), 16'(rd));
          if (w) m_dma_rd = rd; else m_cpu_rd = rd;
          m_last_dma = w;
          done = 1'b1;
        end else if (k == TMO) begin
          ep = w ? 4'b0001 : 4'b0010;
          if (m_to < 255) m_to++;
          done = 1'b1;
        end
        check("gnt_pulse", 16'(pulses()), 16'(ep));
      end
    end
    tick();
    ram_ready = stray;
    ram_rdata = 12'($urandom);
    if (w) dma_load = 1'b0; else cpu_load = 1'b0;
    if (re_cpu && !cpu_load) raise(1'b0);
    if (re_dma && !dma_load) raise(1'b1);
    #1;
    check("rel_load", 16'(ram_load_w[md]), 16'd0);
    check("rel_owner", 16'(owner_w[md]), 16'd0);
    check("rel_pulse", 16'(pulses()), 16'd0);
    check("hold_cpu_rdata", 16'(cpu_rdata_w[md]), 16'(m_cpu_rd));
    check("hold_dma_rdata", 16'(dma_rdata_w[md]), 16'(m_dma_rd));
    tick();
    ram_ready = 1'b0;
  endtask

  task automatic rand_round();
    int r, lat;
    bit w;
    if (!cpu_load && $urandom_range(0, 1) == 1) raise(1'b0);
    if (!dma_load && $urandom_range(0, 1) == 1) raise(1'b1);
    if (!cpu_load && !dma_load) raise(1'($urandom));
    r   = int'($urandom_range(0, 9));
    lat = (r == 0) ? 0 : (r == 1) ? -1 : int'($urandom_range(1, 5));
    serve(lat, 12'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    bit w;
    n_checks = 0; n_errors = 0; md = 0;
    rst = 1'b0; cpu_load = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_load = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    ram_ready = 1'b0; ram_rdata = '0;
    for (int p = 0; p < 2; p++) begin
      md = p;
      apply_reset();
      #1;
      check("rst_load", 16'(ram_load_w[md]), 16'd0);
      check("rst_we", 16'(ram_we_w[md]), 16'd0);
      check("rst_addr", 16'(ram_addr_w[md]), 16'd0);
      check("rst_wdata", 16'(ram_wdata_w[md]), 16'd0);
      check("rst_owner", 16'(owner_w[md]), 16'd0);
      check("rst_pulse", 16'(pulses()), 16'd0);
      check("rst_rdata", {4'd0, cpu_rdata_w[md] | dma_rdata_w[md]}, 16'd0);
      if (md == 0) begin
        cpu_we = 1'b0; cpu_addr = 12'o0100; cpu_load = 1'b1;
        serve(2, 12'o7402, 1'b0, 1'b0, 1'b0, w);
        check("cpu_alone_winner", 16'(w), 16'd0);
        cpu_we = 1'b0; cpu_addr = 12'o0300; cpu_load = 1'b1;
        dma_we = 1'b1; dma_addr = 12'o0200; dma_wdata = 12'o1234; dma_load = 1'b1;
        serve(3, 12'o0055, 1'b0, 1'b0, 1'b0, w);
        check("prio_dma_first", 16'(w), 16'd1);
        serve(1, 12'o0066, 1'b0, 1'b0, 1'b0, w);
        check("cpu_after_dma", 16'(w), 16'd0);
        raise(1'b0); raise(1'b1);
        serve(0, 12'o0000, 1'b0, 1'b0, 1'b0, w);
        check("tmo_dma_winner", 16'(w), 16'd1);
`ifdef MEM_ARB_STATS_EN
        check("stat_timeouts_one", 16'(timeouts_w[md]), 16'd1);
`endif
        serve(2, 12'o5151, 1'b0, 1'b0, 1'b0, w);
        check("cpu_after_tmo", 16'(w), 16'd0);
        raise(1'b0);
        serve(-1, 12'o0000, 1'b0, 1'b0, 1'b0, w);
      end else begin
        raise(1'b0); raise(1'b1);
        for (int i = 0; i < 6; i++) begin
          serve(int'($urandom_range(1, 4)), 12'($urandom), i < 4, i < 4, 1'b0, w);
          check("rr_order", 16'(w), 16'(i % 2));
        end
      end
      for (int i = 0; i < 40; i++) rand_round();
      while (cpu_load || dma_load) serve(2, 12'($urandom), 1'b0, 1'b0, 1'b0, w);
`ifdef MEM_ARB_STATS_EN
      check("stat_cpu_grants", cpu_grants_w[md], 16'(m_cpu_gr));
      check("stat_dma_grants", dma_grants_w[md], 16'(m_dma_gr));
      check("stat_timeouts", 16'(timeouts_w[md]), 16'(m_to));
`endif
      // Asynchronous reset in the middle of a CPU grant.
      raise(1'b0);
      tick();
      ram_ready = 1'b1; ram_rdata = 12'o4321;
      #1;
      check("pre_rst_load", 16'(ram_load_w[md]), 16'd1);
      rst = 1'b1;
      #1;
      check("async_rst_load", 16'(ram_load_w[md]), 16'd0);
      check("async_rst_owner", 16'(owner_w[md]), 16'd0);
      check("async_rst_pulse", 16'(pulses()), 16'd0);
      cpu_load = 1'b0; ram_ready = 1'b0;
      tick();
      rst = 1'b0;
      model_reset();
      #1;
      check("post_rst_rdata", 16'(cpu_rdata_w[md]), 16'd0);
      raise(1'b0);
      serve(2, 12'($urandom), 1'b0, 1'b0, 1'b0, w);
      check("post_rst_winner", 16'(w), 16'd0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
